pipelined_barrel_shifter: RTL

Parametrised, pipelined barrel shifter. Supports logical left, logical right, arithmetic right, rotate left and rotate right on a WIDTH-bit operand. Each shift layer is registered, and valid/ready handshakes sit on both sides. A sideband tag travels with each beat. It replaces the combinational 32-bit left/right shifter in datapaths that need configurable width, rotate/arithmetic modes and timing closure at full clock rate.

---
 rtl/shifter_pkg.sv | 19 +
 rtl/pipelined_barrel_shifter_if.sv | 33 +++
 rtl/shift_stage.sv | 95 +++++++++
 rtl/pipelined_barrel_shifter.sv | 79 +++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared op codes and fill-bit helper for the pipelined barrel shifter.
// The stage payload struct is declared in shift_stage, where its widths are known.
package shifter_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Only SRA fills with the sign bit; every other op fills with zero.
  function automatic logic fill_bit(
    input logic [2:0] op,
    input logic       msb
  );
    return (op == OP_SRA) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready operand and result bundle for the pipelined barrel shifter.
// master drives operands, slave is the shifter.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SHW  = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/shift_stage.sv
// One registered shifter layer: applies a 2^K shift when amount bit K is set.
// Holds one beat with its own valid bit and local advance logic.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int K     = 0,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  input  logic             in_fill,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output logic [2:0]       out_op,
  output logic             out_fill,
  output logic [TAG_W-1:0] out_tag
);

  localparam int S = 1 << K;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [2:0]       op;
    logic             fill;
    logic [TAG_W-1:0] tag;
  } payload_t;

  payload_t         pl_q, pl_d;
  logic             valid_q, valid_d;
  logic             load;
  logic [WIDTH-1:0] layer;
  logic [WIDTH-1:0] shifted;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    layer = in_data;
    unique case (1'b1)
      (in_op == OP_SLL):
        layer = {in_data[WIDTH-S-1:0], {S{1'b0}}};
      (in_op == OP_SRL),
      (in_op == OP_SRA):
        layer = {{S{in_fill}}, in_data[WIDTH-1:S]};
      (in_op == OP_ROL):
        layer = {in_data[WIDTH-S-1:0], in_data[WIDTH-1:WIDTH-S]};
      (in_op == OP_ROR):
        layer = {in_data[S-1:0], in_data[WIDTH-1:S]};
      default:
        layer = in_data;
    endcase
    shifted = in_amt[K] ? layer : in_data;
  end

  always_comb begin
    valid_d = valid_q;
    pl_d    = pl_q;
    if (load) begin
      valid_d = 1'b1;
      pl_d    = '{data: shifted, amt: in_amt, op: in_op,
                  fill: in_fill, tag: in_tag};
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pl_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pl_q    <= pl_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = pl_q.data;
  assign out_amt   = pl_q.amt;
  assign out_op    = pl_q.op;
  assign out_fill  = pl_q.fill;
  assign out_tag   = pl_q.tag;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SHW registered layers chained by valid/ready.
// SLL/SRL/SRA/ROL/ROR with a sideband tag carried alongside each beat.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  pipelined_barrel_shifter_if.slave   bus
);

  for (genvar k = 0; k < SHW; k++) begin : g_st
    logic             i_v, i_r, i_f;
    logic             o_v, o_r, o_f;
    logic [WIDTH-1:0] i_d, o_d;
    logic [SHW-1:0]   i_a, o_a;
    logic [2:0]       i_o, o_o;
    logic [TAG_W-1:0] i_t, o_t;

    if (k == 0) begin : g_head
      // Sign captured once from the original MSB, never from shifted data.
      assign i_v = bus.in_valid && !rst;
      assign i_d = bus.in_data;
      assign i_a = bus.in_amt;
      assign i_o = bus.in_op;
      assign i_f = fill_bit(bus.in_op, bus.in_data[WIDTH-1]);
      assign i_t = bus.in_tag;
    end else begin : g_link
      assign i_v = g_st[k-1].o_v;
      assign i_d = g_st[k-1].o_d;
      assign i_a = g_st[k-1].o_a;
      assign i_o = g_st[k-1].o_o;
      assign i_f = g_st[k-1].o_f;
      assign i_t = g_st[k-1].o_t;
    end

    if (k == SHW - 1) begin : g_tail
      assign o_r = bus.out_ready;
    end else begin : g_mid
      assign o_r = g_st[k+1].i_r;
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .K     (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (i_v),
      .in_ready  (i_r),
      .in_data   (i_d),
      .in_amt    (i_a),
      .in_op     (i_o),
      .in_fill   (i_f),
      .in_tag    (i_t),
      .out_valid (o_v),
      .out_ready (o_r),
      .out_data  (o_d),
      .out_amt   (o_a),
      .out_op    (o_o),
      .out_fill  (o_f),
      .out_tag   (o_t)
    );
  end

  assign bus.in_ready  = g_st[0].i_r && !rst;
  assign bus.out_valid = g_st[SHW-1].o_v;
  assign bus.out_data  = g_st[SHW-1].o_d;
  assign bus.out_tag   = g_st[SHW-1].o_t;

  logic unused_tail;
  assign unused_tail = ^{g_st[SHW-1].o_a, g_st[SHW-1].o_o,
                         g_st[SHW-1].o_f};

endmodule
